// File: rtl/keypad_pkg.sv
// Shared constants and scan-state encoding for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StScan = 1'b1
    } scan_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs. It resets to all ones,
// which matches the idle level of pulled-up lines.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Each row is driven low for SCAN_DIV cycles and
// complete scans are debounced over DEBOUNCE_SCANS before the key vector is published.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic                keys_valid_out,
    output logic                any_key_out
);

    localparam logic [15:0] CntLast   = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  StableMax = 4'(DEBOUNCE_SCANS);

    scan_state_e         state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] scan_vec_q, scan_vec_d;
    logic [NUM_KEYS-1:0] cand_q, cand_d;
    logic [3:0]          stable_q, stable_d;
    logic [NUM_KEYS-1:0] keys_q, keys_d;
    logic                valid_q, valid_d;
    logic [NUM_KEYS-1:0] new_vec;
    logic [NUM_COLS-1:0] col_sync;

    sync_2ff #(
        .WIDTH (NUM_COLS)
    ) u_col_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (col_in),
        .q_o     (col_sync)
    );

    always_comb begin
        state_d    = enable ? StScan : StIdle;
        row_d      = row_q;
        cnt_d      = cnt_q;
        scan_vec_d = scan_vec_q;
        cand_d     = cand_q;
        stable_d   = stable_q;
        keys_d     = keys_q;
        valid_d    = 1'b0;

        // Scan vector with the row being sampled this cycle merged in.
        new_vec = scan_vec_q;
        new_vec[{row_q, 2'b00} +: NUM_COLS] = ~col_sync;

        if (state_q == StIdle) begin
            row_d = 2'd0;
            cnt_d = 16'd0;
        end else if (cnt_q == CntLast) begin
            cnt_d      = 16'd0;
            row_d      = row_q + 2'd1;
            scan_vec_d = new_vec;
            if (row_q == 2'd3) begin
                if (new_vec == cand_q) begin
                    if (stable_q < StableMax) begin
                        stable_d = stable_q + 4'd1;
                    end
                end else begin
                    cand_d   = new_vec;
                    stable_d = 4'd1;
                end
                if ((stable_d == StableMax) && (cand_d != keys_q)) begin
                    keys_d  = cand_d;
                    valid_d = 1'b1;
                end
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            row_q      <= 2'd0;
            cnt_q      <= 16'd0;
            scan_vec_q <= '0;
            cand_q     <= '0;
            stable_q   <= 4'd0;
            keys_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            scan_vec_q <= scan_vec_d;
            cand_q     <= cand_d;
            stable_q   <= stable_d;
            keys_q     <= keys_d;
            valid_q    <= valid_d;
        end
    end

    // Outputs are decoded from registers only, so col_in never reaches them combinationally.
    always_comb begin
        row_out = 4'hF;
        if (state_q == StScan) begin
            row_out = ~(4'b0001 << row_q);
        end
    end

    assign keys_out       = keys_q;
    assign keys_valid_out = valid_q;
    assign any_key_out    = |keys_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives the columns, and a
// scoreboard holds the key vectors expected on each keys_valid_out pulse.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DB       = 2;

    typedef struct packed {
        logic [15:0] keys;
        logic        any;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys_out;
    logic        keys_valid_out;
    logic        any_key_out;
    logic [15:0] pressed = 16'h0000;
    logic        prev_valid = 1'b0;
    logic [3:0]  exp_row;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n;
    int          k;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .col_in         (col_in),
        .row_out        (row_out),
        .keys_out       (keys_out),
        .keys_valid_out (keys_valid_out),
        .any_key_out    (any_key_out)
    );

    // A column reads low when a pressed key sits in a row that is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] enc16(input logic [15:0] v);
        enc16 = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) enc16 = i[3:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n is the edge index (first edge after the call is 0) at which the pulse is seen.
    task automatic wait_pulse(input int limit, output int cnt);
        cnt = -1;
        do begin
            tick();
            cnt++;
        end while (!keys_valid_out && cnt < limit);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (keys_valid_out) begin
            check_eq("valid_consecutive", {31'd0, prev_valid}, 32'd0);
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", {31'd0, keys_valid_out}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_keys", {16'd0, keys_out}, {16'd0, e.keys});
                check_eq("sb_any", {31'd0, any_key_out}, {31'd0, e.any});
            end
        end
        prev_valid = keys_valid_out;
    end

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check_eq("rst_row", {28'd0, row_out}, 32'hF);
        check_eq("rst_keys", {16'd0, keys_out}, 32'h0);
        check_eq("rst_valid", {31'd0, keys_valid_out}, 32'h0);
        check_eq("rst_any", {31'd0, any_key_out}, 32'h0);
        reset = 1'b0;
        tick();

        // Idle scanning, no keys pressed.
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i < 16) begin
                exp_row = ~(4'b0001 << ((i / 4) % 4));
                check_eq($sformatf("row_cycle%0d", i), {28'd0, row_out}, {28'd0, exp_row});
            end
        end
        check_eq("nokey_keys", {16'd0, keys_out}, 32'h0);

        // Single key at row 2 / col 1.
        enable = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        sb_q.push_back('{keys: 16'h0200, any: 1'b1});
        pressed = 16'h0200;
        enable = 1'b1;
        wait_pulse(100, n);
        check_eq("key9_latency", n, 32);
        check_eq("key9_keys", {16'd0, keys_out}, 32'h0200);
        check_eq("key9_enc", {28'd0, enc16(keys_out)}, 32'd9);

        // Drop enable in the middle of row 1, then resume.
        k = 0;
        while (row_out != 4'hD && k < 50) begin
            tick();
            k++;
        end
        tick();
        enable = 1'b0;
        tick();
        check_eq("dis_row", {28'd0, row_out}, 32'hF);
        check_eq("dis_keys", {16'd0, keys_out}, 32'h0200);
        repeat (3) tick();
        check_eq("dis_row_hold", {28'd0, row_out}, 32'hF);
        enable = 1'b1;
        tick();
        check_eq("reen_row0", {28'd0, row_out}, 32'hE);
        repeat (3) tick();
        check_eq("reen_row0_end", {28'd0, row_out}, 32'hE);
        tick();
        check_eq("reen_row1", {28'd0, row_out}, 32'hD);

        // Reset while keys are reported, mid-scan.
        repeat (5) tick();
        check_eq("pre_rst_keys", {16'd0, keys_out}, 32'h0200);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_row", {28'd0, row_out}, 32'hF);
        check_eq("mid_rst_keys", {16'd0, keys_out}, 32'h0);
        check_eq("mid_rst_valid", {31'd0, keys_valid_out}, 32'h0);
        check_eq("mid_rst_any", {31'd0, any_key_out}, 32'h0);
        reset = 1'b0;
        enable = 1'b0;
        pressed = 16'h0000;
        tick();

        // Key 5 bouncing on alternate scans never settles.
        pressed = 16'h0020;
        enable = 1'b1;
        for (int i = 0; i < 160; i++) begin
            tick();
            pressed = (((i / 16) % 2) == 0) ? 16'h0020 : 16'h0000;
        end
        check_eq("bounce_keys", {16'd0, keys_out}, 32'h0);
        enable = 1'b0;
        pressed = 16'h0000;
        repeat (2) tick();

        // Two corner keys together, then release.
        sb_q.push_back('{keys: 16'h8001, any: 1'b1});
        pressed = 16'h8001;
        enable = 1'b1;
        wait_pulse(200, n);
        check_eq("corner_latency", n, 32);
        check_eq("corner_any", {31'd0, any_key_out}, 32'h1);
        sb_q.push_back('{keys: 16'h0000, any: 1'b0});
        pressed = 16'h0000;
        wait_pulse(200, n);
        check_eq("release_latency", n, 31);
        repeat (40) tick();
        check_eq("release_keys", {16'd0, keys_out}, 32'h0);
        check_eq("release_any", {31'd0, any_key_out}, 32'h0);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
